cd_rx_page_ctrl: RTL and testbench
==================================

Name: cd_rx_page_ctrl

Overview:
- Page manager for the multi-page receive RAM written by the receive byte engine.
- Tracks which page the receive engine owns and which pages are free.
- Holds a FIFO of completed pages, with their flags, for the CSR/host reader.
- Allocates a fresh page on every frame switch, reports overruns when none is free, and recycles pages when the host releases them.

Parameters:
PAGES, 4, number of receive RAM pages (2..8)
PAGE_AW, 3, page index width; must satisfy 2**PAGE_AW >= PAGES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_switch  in  1  one-cycle pulse from receive engine: current page complete
rx_flags  in  8  frame flags, valid with rx_switch (0 = good, else rx length / 0xff)
wr_page  out  PAGE_AW  page the receive engine currently writes
rd_valid  out  1  ready FIFO non-empty
rd_page  out  PAGE_AW  page at FIFO head (valid when rd_valid)
rd_flags  out  8  flags of FIFO head page
rd_release  in  1  host pulse: head page consumed, return it to the free pool
rd_clean  in  1  host pulse: discard all queued pages
pend_cnt  out  PAGE_AW+1  number of queued pages
free_cnt  out  PAGE_AW+1  number of free pages
rx_lost  out  1  one-cycle pulse: switch arrived with no free page
lost_cnt  out  8  saturating overrun counter
lost_clr  in  1  clear lost_cnt

Behaviour:
- Reset values:
  - wr_page=0, free bitmap = pages 1..PAGES-1, FIFO empty.
  - rd_valid=0, rd_page=0, rd_flags=0, pend_cnt=0, free_cnt=PAGES-1.
  - rx_lost=0, lost_cnt=0.
- Invariant: every page is in exactly one of {writer, free, queued}.
  - pend_cnt + free_cnt + 1 == PAGES at every cycle.
- All outputs are registered.
- Each event takes effect on the cycle after its input pulse (latency 1).
- Free pool:
  - PAGES-bit bitmap.
  - Allocation picks the lowest-indexed set bit (fixed priority).
- Ready FIFO:
  - Circular buffer of depth PAGES-1 holding {page, flags}.
  - Read/write pointers wrap modulo PAGES-1.
  - rd_page/rd_flags show the head entry, registered.
- rx_switch with a free page available:
  - Push {wr_page, rx_flags} into the FIFO.
  - wr_page <= lowest free page; clear that page's free bit.
  - pend_cnt+1, free_cnt-1.
- rx_switch with no free page (overrun):
  - FIFO unchanged; wr_page unchanged, so the frame is overwritten.
  - rx_lost=1 for one cycle.
  - lost_cnt+1, saturating at 255.
- rd_release with rd_valid=1:
  - Pop the head; set the head page's free bit.
  - pend_cnt-1, free_cnt+1.
- rd_release with rd_valid=0: ignored.
- rx_switch and rd_release in the same cycle:
  - The release is evaluated first, and the freed page is eligible for this cycle's allocation.
  - Consequently, a switch never overruns while a valid release is present.
  - Net effect: pend_cnt unchanged; free_cnt = old free_cnt.
- rd_clean:
  - Empties the FIFO and resets both pointers.
  - Every page except wr_page becomes free: pend_cnt=0, free_cnt=PAGES-1.
  - Has priority over rd_release and rx_switch in the same cycle.
    - A coincident switch's frame is discarded: no push, and wr_page stays unchanged.
    - A coincident switch does not raise rx_lost.
- lost_clr:
  - lost_cnt <= 0.
  - If coincident with an overrun, lost_cnt <= 1 and rx_lost still pulses.
- reset mid-operation: returns to reset values next cycle regardless of other inputs.
- The writer page is never freed or queued except through rx_switch.
- rx_switch is assumed to be a single-cycle pulse; back-to-back pulses are each handled, one per cycle.

Decomposition:
- Shared package cd_rx_page_pkg:
  - Parameter bounds, and a FLAG_OK=8'h00 constant.
  - Struct/typedef rx_page_entry_t {page, flags} used by the FIFO and the CSR decode.
- One sub-module is natural: cd_rx_page_fifo.
  - Circular {page, flags} FIFO with push/pop/clear, count and registered head outputs.
- The free bitmap, priority encoder and counters stay in the top module.

Test Plan:
- Reset, PAGES=4: wr_page=0, free_cnt=3, pend_cnt=0, rd_valid=0, lost_cnt=0.
- Three switches with flags 0x00, 0x12, 0x00:
  - wr_page sequence 1, 2, 3.
  - FIFO head = {0, 0x00}; pend_cnt=3, free_cnt=0.
- Fourth switch with the pool empty:
  - rx_lost pulses, lost_cnt=1, wr_page stays 3, pend_cnt stays 3.
  - 256 further overruns leave lost_cnt=255.
- Release with pend_cnt=3, free_cnt=0, asserted with a switch in the same cycle:
  - Page 0 freed and allocated: wr_page=0, FIFO tail={3, flags}.
  - rd_page=1, pend_cnt=3, no rx_lost.
- rd_clean with a coincident rx_switch:
  - pend_cnt=0, free_cnt=3, rd_valid=0, wr_page unchanged, no rx_lost.
- Release on an empty FIFO, and reset asserted mid-sequence:
  - Release is ignored: counts unchanged.
  - Reset restores all reset values next cycle.

Source files
------------

// File: rtl/cd_rx_page_pkg.sv
// Shared types and constants for the receive page manager.
package cd_rx_page_pkg;

    localparam int PAGES_MIN    = 2;
    localparam int PAGES_MAX    = 8;
    localparam int ENTRY_PAGE_W = 4;

    localparam logic [7:0] FLAG_OK = 8'h00;

    // Page field is sized for the largest legal page index; users narrow it on read.
    typedef struct packed {
        logic [ENTRY_PAGE_W-1:0] page;
        logic [7:0]              flags;
    } rx_page_entry_t;

endpackage

// File: rtl/cd_rx_page_fifo.sv
// Circular FIFO of completed {page, flags} entries with a registered head view.
module cd_rx_page_fifo
    import cd_rx_page_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int PAGE_AW = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  rx_page_entry_t     push_data,
    input  logic               pop,
    output rx_page_entry_t     head,
    output logic               valid,
    output logic [PAGE_AW:0]   count
);

    localparam logic [PAGE_AW:0]   DEPTH_C = (PAGE_AW+1)'(DEPTH);
    localparam logic [PAGE_AW-1:0] LAST_C  = PAGE_AW'(DEPTH-1);

    rx_page_entry_t     mem [DEPTH];
    logic [PAGE_AW-1:0] rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
    logic [PAGE_AW:0]   count_nx;
    logic               do_push, do_pop;
    rx_page_entry_t     head_nx;

    function automatic logic [PAGE_AW-1:0] ptr_inc(input logic [PAGE_AW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop    = pop && (count != '0);
        do_push   = push && ((count != DEPTH_C) || do_pop);
        rd_ptr_nx = rd_ptr;
        wr_ptr_nx = wr_ptr;
        count_nx  = count;
        if (clear) begin
            rd_ptr_nx = '0;
            wr_ptr_nx = '0;
            count_nx  = '0;
        end else begin
            if (do_pop)  rd_ptr_nx = ptr_inc(rd_ptr);
            if (do_push) wr_ptr_nx = ptr_inc(wr_ptr);
            if (do_push && !do_pop)      count_nx = count + 1'b1;
            else if (do_pop && !do_push) count_nx = count - 1'b1;
        end
        // The entry being written this cycle may itself become the new head.
        head_nx = '0;
        head_nx.flags = FLAG_OK;
        if (count_nx != '0) begin
            if (do_push && !clear && (wr_ptr == rd_ptr_nx)) head_nx = push_data;
            else                                            head_nx = mem[rd_ptr_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_ptr_nx;
            wr_ptr <= wr_ptr_nx;
            count  <= count_nx;
            valid  <= (count_nx != '0);
            head   <= head_nx;
        end
    end

endmodule

// File: rtl/cd_rx_page_ctrl.sv
// Receive RAM page manager: writer page, free pool, ready FIFO and overrun accounting.
module cd_rx_page_ctrl
    import cd_rx_page_pkg::*;
#(
    parameter int PAGES   = 4,
    parameter int PAGE_AW = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_switch,
    input  logic [7:0]         rx_flags,
    output logic [PAGE_AW-1:0] wr_page,
    output logic               rd_valid,
    output logic [PAGE_AW-1:0] rd_page,
    output logic [7:0]         rd_flags,
    input  logic               rd_release,
    input  logic               rd_clean,
    output logic [PAGE_AW:0]   pend_cnt,
    output logic [PAGE_AW:0]   free_cnt,
    output logic               rx_lost,
    output logic [7:0]         lost_cnt,
    input  logic               lost_clr
);

    if (PAGES < PAGES_MIN || PAGES > PAGES_MAX || (1 << PAGE_AW) < PAGES ||
        PAGE_AW > ENTRY_PAGE_W) begin : g_param_check
        $error("cd_rx_page_ctrl: illegal PAGES/PAGE_AW combination");
    end

    localparam logic [PAGE_AW:0]  FREE_RST  = (PAGE_AW+1)'(PAGES-1);
    localparam logic [PAGES-1:0]  POOL_RST  = {{(PAGES-1){1'b1}}, 1'b0};

    logic [PAGES-1:0]   free_q, free_rel, free_nx;
    logic [PAGE_AW:0]   free_cnt_nx;
    logic [PAGE_AW-1:0] alloc_page;
    logic               alloc_found, release_ok, switch_ok, lost_nx;
    rx_page_entry_t     push_data, head;

    assign release_ok = rd_release && rd_valid;

    always_comb begin
        // The release is applied before allocation so its page can be reused at once.
        free_rel = free_q;
        if (release_ok) free_rel[rd_page] = 1'b1;

        alloc_found = 1'b0;
        alloc_page  = '0;
        for (int i = PAGES - 1; i >= 0; i--) begin
            if (free_rel[i]) begin
                alloc_found = 1'b1;
                alloc_page  = PAGE_AW'(i);
            end
        end

        switch_ok = rx_switch && alloc_found && !rd_clean;
        lost_nx   = rx_switch && !alloc_found && !rd_clean;

        if (rd_clean) begin
            free_nx = '1;
            free_nx[wr_page] = 1'b0;
        end else begin
            free_nx = free_rel;
            if (switch_ok) free_nx[alloc_page] = 1'b0;
        end

        free_cnt_nx = '0;
        for (int i = 0; i < PAGES; i++) begin
            free_cnt_nx = free_cnt_nx + (PAGE_AW+1)'(free_nx[i]);
        end

        push_data       = '0;
        push_data.page  = ENTRY_PAGE_W'(wr_page);
        push_data.flags = rx_flags;
    end

    cd_rx_page_fifo #(
        .DEPTH   (PAGES - 1),
        .PAGE_AW (PAGE_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (rd_clean),
        .push      (switch_ok),
        .push_data (push_data),
        .pop       (release_ok && !rd_clean),
        .head      (head),
        .valid     (rd_valid),
        .count     (pend_cnt)
    );

    assign rd_page  = PAGE_AW'(head.page);
    assign rd_flags = head.flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_page  <= '0;
            free_q   <= POOL_RST;
            free_cnt <= FREE_RST;
            rx_lost  <= 1'b0;
            lost_cnt <= 8'd0;
        end else begin
            free_q   <= free_nx;
            free_cnt <= free_cnt_nx;
            rx_lost  <= lost_nx;
            if (switch_ok) wr_page <= alloc_page;
            if (lost_clr)                         lost_cnt <= {7'd0, lost_nx};
            else if (lost_nx && lost_cnt != 8'hff) lost_cnt <= lost_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cd_rx_page_ctrl.sv
// Self-checking bench for cd_rx_page_ctrl: directed walk plus randomized traffic vs a queue model.
module tb_cd_rx_page_ctrl;

    localparam int PAGES   = 4;
    localparam int PAGE_AW = 3;

    logic               clk = 1'b0;
    logic               reset, rx_switch, rd_release, rd_clean, lost_clr;
    logic [7:0]         rx_flags;
    logic [PAGE_AW-1:0] wr_page, rd_page;
    logic               rd_valid, rx_lost;
    logic [7:0]         rd_flags, lost_cnt;
    logic [PAGE_AW:0]   pend_cnt, free_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cd_rx_page_ctrl #(.PAGES(PAGES), .PAGE_AW(PAGE_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_switch  (rx_switch),
        .rx_flags   (rx_flags),
        .wr_page    (wr_page),
        .rd_valid   (rd_valid),
        .rd_page    (rd_page),
        .rd_flags   (rd_flags),
        .rd_release (rd_release),
        .rd_clean   (rd_clean),
        .pend_cnt   (pend_cnt),
        .free_cnt   (free_cnt),
        .rx_lost    (rx_lost),
        .lost_cnt   (lost_cnt),
        .lost_clr   (lost_clr)
    );

    // Behavioural model: queued {page, flags}, set of free pages, writer page, overrun count.
    logic [PAGE_AW+7:0] exp_q[$];
    bit                 m_free [PAGES];
    int                 m_wr, m_lost_cnt, m_alloc, m_nfree;
    bit                 m_lost, m_lost_now, m_ready = 0;
    logic [PAGE_AW+7:0] m_ent;

    always @(posedge clk) begin
        if (reset) begin
            m_wr = 0;
            for (int i = 0; i < PAGES; i++) m_free[i] = (i != 0);
            exp_q.delete();
            m_lost = 0;
            m_lost_cnt = 0;
        end else begin
            m_lost_now = 0;
            if (rd_clean) begin
                exp_q.delete();
                for (int i = 0; i < PAGES; i++) m_free[i] = (i != m_wr);
            end else begin
                if (rd_release && exp_q.size() > 0) begin
                    m_ent = exp_q.pop_front();
                    m_free[int'(m_ent[PAGE_AW+7:8])] = 1;
                end
                if (rx_switch) begin
                    m_alloc = -1;
                    for (int i = PAGES - 1; i >= 0; i--) if (m_free[i]) m_alloc = i;
                    if (m_alloc < 0) m_lost_now = 1;
                    else begin
                        exp_q.push_back({PAGE_AW'(m_wr), rx_flags});
                        m_free[m_alloc] = 0;
                        m_wr = m_alloc;
                    end
                end
            end
            m_lost = m_lost_now;
            if (lost_clr)                          m_lost_cnt = m_lost_now ? 1 : 0;
            else if (m_lost_now && m_lost_cnt < 255) m_lost_cnt++;
        end
        m_nfree = 0;
        for (int i = 0; i < PAGES; i++) m_nfree += int'(m_free[i]);
        m_ready = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("wr_page",  32'(wr_page),  32'(m_wr));
            chk("pend_cnt", 32'(pend_cnt), 32'(exp_q.size()));
            chk("free_cnt", 32'(free_cnt), 32'(m_nfree));
            chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
            chk("rx_lost",  32'(rx_lost),  32'(m_lost));
            chk("lost_cnt", 32'(lost_cnt), 32'(m_lost_cnt));
            chk("invariant", 32'(pend_cnt) + 32'(free_cnt) + 1, PAGES);
            if (exp_q.size() > 0) begin
                m_ent = exp_q[0];
                chk("rd_page",  32'(rd_page),  32'(m_ent[PAGE_AW+7:8]));
                chk("rd_flags", 32'(rd_flags), 32'(m_ent[7:0]));
            end
        end
    end

    task automatic cyc(input bit sw, input logic [7:0] fl, input bit rel, input bit cln,
                       input bit lc, input bit rst);
        rx_switch = sw; rx_flags = fl; rd_release = rel; rd_clean = cln;
        lost_clr = lc; reset = rst;
        @(posedge clk);
        #1;
        rx_switch = 0; rx_flags = 8'h00; rd_release = 0; rd_clean = 0;
        lost_clr = 0; reset = 0;
    endtask

    initial begin
        rx_switch = 0; rx_flags = 8'h00; rd_release = 0; rd_clean = 0;
        lost_clr = 0; reset = 1;
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 1);

        chk("rst wr_page",  32'(wr_page), 0);
        chk("rst free_cnt", 32'(free_cnt), 3);
        chk("rst pend_cnt", 32'(pend_cnt), 0);
        chk("rst rd_valid", 32'(rd_valid), 0);
        chk("rst lost_cnt", 32'(lost_cnt), 0);
        chk("rst rd_page",  32'(rd_page), 0);
        chk("rst rd_flags", 32'(rd_flags), 0);

        cyc(1, 8'h00, 0, 0, 0, 0); chk("sw1 wr_page", 32'(wr_page), 1);
        cyc(1, 8'h12, 0, 0, 0, 0); chk("sw2 wr_page", 32'(wr_page), 2);
        cyc(1, 8'h00, 0, 0, 0, 0); chk("sw3 wr_page", 32'(wr_page), 3);
        chk("sw3 rd_page",  32'(rd_page), 0);
        chk("sw3 rd_flags", 32'(rd_flags), 8'h00);
        chk("sw3 pend_cnt", 32'(pend_cnt), 3);
        chk("sw3 free_cnt", 32'(free_cnt), 0);

        cyc(1, 8'hab, 0, 0, 0, 0);
        chk("ovr rx_lost",  32'(rx_lost), 1);
        chk("ovr lost_cnt", 32'(lost_cnt), 1);
        chk("ovr wr_page",  32'(wr_page), 3);
        chk("ovr pend_cnt", 32'(pend_cnt), 3);
        cyc(0, 8'h00, 0, 0, 0, 0);
        chk("ovr pulse end", 32'(rx_lost), 0);

        for (int i = 0; i < 256; i++) cyc(1, 8'(i), 0, 0, 0, 0);
        chk("sat lost_cnt", 32'(lost_cnt), 255);
        cyc(0, 8'h00, 0, 0, 1, 0);
        chk("clr lost_cnt", 32'(lost_cnt), 0);
        cyc(1, 8'h00, 0, 0, 1, 0);
        chk("clr+ovr lost_cnt", 32'(lost_cnt), 1);
        chk("clr+ovr rx_lost",  32'(rx_lost), 1);

        cyc(1, 8'h55, 1, 0, 0, 0);
        chk("rel+sw wr_page",  32'(wr_page), 0);
        chk("rel+sw rd_page",  32'(rd_page), 1);
        chk("rel+sw rd_flags", 32'(rd_flags), 8'h12);
        chk("rel+sw pend_cnt", 32'(pend_cnt), 3);
        chk("rel+sw free_cnt", 32'(free_cnt), 0);
        chk("rel+sw rx_lost",  32'(rx_lost), 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        chk("tail rd_page",  32'(rd_page), 3);
        chk("tail rd_flags", 32'(rd_flags), 8'h55);
        chk("tail pend_cnt", 32'(pend_cnt), 1);
        chk("tail free_cnt", 32'(free_cnt), 2);

        cyc(1, 8'h77, 0, 1, 0, 0);
        chk("clean pend_cnt", 32'(pend_cnt), 0);
        chk("clean free_cnt", 32'(free_cnt), 3);
        chk("clean rd_valid", 32'(rd_valid), 0);
        chk("clean wr_page",  32'(wr_page), 0);
        chk("clean rx_lost",  32'(rx_lost), 0);

        cyc(0, 8'h00, 1, 0, 0, 0);
        chk("empty rel pend", 32'(pend_cnt), 0);
        chk("empty rel free", 32'(free_cnt), 3);

        cyc(1, 8'h01, 0, 0, 0, 0);
        chk("pre-rst wr_page", 32'(wr_page), 1);
        cyc(1, 8'h02, 1, 0, 0, 1);
        chk("mid-rst wr_page",  32'(wr_page), 0);
        chk("mid-rst pend_cnt", 32'(pend_cnt), 0);
        chk("mid-rst free_cnt", 32'(free_cnt), 3);
        chk("mid-rst rd_valid", 32'(rd_valid), 0);
        chk("mid-rst lost_cnt", 32'(lost_cnt), 0);

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(1, 0) == 1,
                ($urandom_range(1, 0) == 1) ? 8'h00 : 8'($urandom_range(255, 1)),
                $urandom_range(2, 0) == 0,
                $urandom_range(39, 0) == 0,
                $urandom_range(39, 0) == 0,
                $urandom_range(199, 0) == 0);
        end
        cyc(0, 8'h00, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
